// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak squeeze datapath.
//   W / STATE_W / LEN_W   : lane width, Keccak state width, length-counter width
//   RATE128_WORDS         : SHAKE128 rate in 64-bit lanes
//   RATE256_WORDS         : SHAKE256 rate in 64-bit lanes
//   sq_state_e            : squeeze FSM state encoding
//   rate_buf_t            : rate-sized lane buffer (largest rate)
package keccak_pkg;

  localparam int W             = 64;
  localparam int STATE_W       = 1600;
  localparam int LEN_W         = 16;
  localparam int RATE128_WORDS = 21;
  localparam int RATE256_WORDS = 17;
  localparam int RATE_MAX      = RATE128_WORDS;
  localparam int IDX_W         = 5;

  typedef enum logic [1:0] {
    SQ_IDLE    = 2'd0,
    SQ_WAIT_ST = 2'd1,
    SQ_DRAIN   = 2'd2,
    SQ_DONE    = 2'd3
  } sq_state_e;

  typedef logic [RATE_MAX-1:0][W-1:0] rate_buf_t;

  // Rate in lanes for the selected XOF: 0 = SHAKE128, 1 = SHAKE256.
  function automatic logic [IDX_W-1:0] rate_words(input logic mode);
    return mode ? IDX_W'(RATE256_WORDS) : IDX_W'(RATE128_WORDS);
  endfunction

endpackage

// File: rtl/keccak_lane_mux.sv
// Combinational lane selector: returns lane idx_i of a captured rate block.
//   buf_i  : rate buffer (lane k in element k)
//   idx_i  : lane index
//   lane_o : selected lane, zero for an index beyond the buffer
module keccak_lane_mux
  import keccak_pkg::*;
(
  input  rate_buf_t        buf_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [W-1:0]     lane_o
);

  always_comb begin
    lane_o = '0;
    if (idx_i < IDX_W'(RATE_MAX)) lane_o = buf_i[idx_i];
  end

endmodule

// File: rtl/keccak_squeeze_ser.sv
// SHAKE squeeze serializer: captures the rate part of a permuted Keccak state and
// streams it as 64-bit words over valid/ready, requesting further permutations
// when a rate block runs out and more output is owed.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start_i, mode_i, len_words_i: begin squeeze (mode 0 = SHAKE128, 1 = SHAKE256)
//   state_i, state_valid_i      : permuted state and its strobe
//   perm_req_o                  : pulse requesting the next permutation
//   dout_o, dout_valid_o, dout_ready_i : output word stream
//   busy_o, done_o              : activity flag, end-of-squeeze pulse
// Build option: SQUEEZE_PREFETCH_EN adds a shadow rate buffer so the next block is
// fetched while the current one drains (no bubble at block boundaries).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start_i
// WAIT_ST  | waiting for a permuted state to capture
// DRAIN    | presenting rate lanes one per handshake
// DONE     | one-cycle done_o pulse
module keccak_squeeze_ser
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [LEN_W-1:0]   len_words_i,
  input  logic [STATE_W-1:0] state_i,
  input  logic               state_valid_i,
  output logic               perm_req_o,
  output logic [W-1:0]       dout_o,
  output logic               dout_valid_o,
  input  logic               dout_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  sq_state_e        st_q, st_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d, rem_dec, rate_len;
  logic [IDX_W-1:0] idx_q, idx_d, rate;
  rate_buf_t        rbuf_q, rbuf_d, cap;
  logic [W-1:0]     lane;
  logic             hs, blk_end, perm_req;
  logic             unused_state;
`ifdef SQUEEZE_PREFETCH_EN
  rate_buf_t        shd_q, shd_d;
  logic             shd_full_q, shd_full_d;
`endif

  // Only the rate lanes are ever emitted; capacity lanes are dropped here.
  always_comb begin
    for (int k = 0; k < RATE_MAX; k++) cap[k] = state_i[k*W +: W];
  end
  assign unused_state = ^state_i[STATE_W-1:RATE_MAX*W];

  keccak_lane_mux u_lane_mux (
    .buf_i  (rbuf_q),
    .idx_i  (idx_q),
    .lane_o (lane)
  );

  assign rate     = rate_words(mode_q);
  assign rate_len = LEN_W'(rate);
  assign hs       = (st_q == SQ_DRAIN) && dout_ready_i;
  assign blk_end  = (idx_q == IDX_W'(rate - 1'b1));
  assign rem_dec  = (rem_q == '0) ? '0 : rem_q - 1'b1;

  assign dout_valid_o = (st_q == SQ_DRAIN);
  assign dout_o       = dout_valid_o ? lane : '0;
  assign busy_o       = (st_q != SQ_IDLE);
  assign done_o       = (st_q == SQ_DONE);
  assign perm_req_o   = perm_req;

  always_comb begin
    st_d     = st_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    rbuf_d   = rbuf_q;
    perm_req = 1'b0;
`ifdef SQUEEZE_PREFETCH_EN
    shd_d      = shd_q;
    shd_full_d = shd_full_q;
`endif
    case (st_q)
      SQ_IDLE: begin
        if (start_i) begin
          if (len_words_i != '0) begin
            mode_d = mode_i;
            rem_d  = len_words_i;
            st_d   = SQ_WAIT_ST;
          end else begin
            st_d = SQ_DONE;
          end
        end
      end
      SQ_WAIT_ST: begin
        if (state_valid_i) begin
          rbuf_d = cap;
          idx_d  = '0;
          st_d   = SQ_DRAIN;
`ifdef SQUEEZE_PREFETCH_EN
          // Fetch the following block early if this one cannot cover the rest.
          if (rem_q > rate_len) perm_req = 1'b1;
`endif
        end
      end
      SQ_DRAIN: begin
`ifdef SQUEEZE_PREFETCH_EN
        if (state_valid_i && !shd_full_q) begin
          shd_d      = cap;
          shd_full_d = 1'b1;
        end
`endif
        if (hs) begin
          rem_d = rem_dec;
          idx_d = idx_q + 1'b1;
          if (rem_dec == '0) begin
            idx_d = '0;
            st_d  = SQ_DONE;
          end else if (blk_end) begin
            idx_d = '0;
`ifdef SQUEEZE_PREFETCH_EN
            // The outstanding request is still in flight when the shadow is
            // empty, so no new request is issued on the way to WAIT_ST.
            if (shd_full_q) begin
              rbuf_d     = shd_q;
              shd_full_d = 1'b0;
              if (rem_dec > rate_len) perm_req = 1'b1;
            end else if (state_valid_i) begin
              rbuf_d     = cap;
              shd_full_d = 1'b0;
              if (rem_dec > rate_len) perm_req = 1'b1;
            end else begin
              st_d = SQ_WAIT_ST;
            end
`else
            perm_req = 1'b1;
            st_d     = SQ_WAIT_ST;
`endif
          end
        end
      end
      SQ_DONE: begin
        st_d = SQ_IDLE;
`ifdef SQUEEZE_PREFETCH_EN
        shd_full_d = 1'b0;
`endif
      end
      default: st_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= SQ_IDLE;
      mode_q <= 1'b0;
      rem_q  <= '0;
      idx_q  <= '0;
      rbuf_q <= '0;
`ifdef SQUEEZE_PREFETCH_EN
      shd_q      <= '0;
      shd_full_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      rem_q  <= rem_d;
      idx_q  <= idx_d;
      rbuf_q <= rbuf_d;
`ifdef SQUEEZE_PREFETCH_EN
      shd_q      <= shd_d;
      shd_full_q <= shd_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_ser.sv
// Scoreboard bench for keccak_squeeze_ser (default single-buffer build).
module tb_keccak_squeeze_ser;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          mode_i;
  logic [15:0]   len_words_i;
  logic [1599:0] state_i;
  logic          state_valid_i;
  logic          perm_req_o;
  logic [63:0]   dout_o;
  logic          dout_valid_o;
  logic          dout_ready_i;
  logic          busy_o;
  logic          done_o;

  keccak_squeeze_ser dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .len_words_i   (len_words_i),
    .state_i       (state_i),
    .state_valid_i (state_valid_i),
    .perm_req_o    (perm_req_o),
    .dout_o        (dout_o),
    .dout_valid_o  (dout_valid_o),
    .dout_ready_i  (dout_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  logic [63:0] base_tab[8];
  int  cur_rate = 21;
  int  hs_cnt, perm_cnt, done_cnt, valid_cnt;
  int  first_hs_cyc, last_hs_cyc, done_cyc, start_cyc;
  bit  perm_flag;
  bit  prev_stall = 1'b0;
  logic [63:0] prev_dout;
  logic [63:0] e_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lane k of a block = base + k for the rate lanes; capacity lanes hold junk.
  function automatic logic [1599:0] mk_state(input logic [63:0] base, input int rate);
    logic [1599:0] s;
    for (int k = 0; k < 25; k++)
      s[k*64 +: 64] = (k < rate) ? base + 64'(k) : ~base ^ 64'(k);
    return s;
  endfunction

  // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit hs;
    if (rst_n) begin
      if (dout_valid_o) valid_cnt++;
      if (prev_stall) begin
        chk("hold_valid", 64'(dout_valid_o), 64'd1);
        chk("hold_data", dout_o, prev_dout);
      end
      hs = dout_valid_o && dout_ready_i;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", dout_o, 64'hFFFF_FFFF_FFFF_FFFF ^ dout_o);
        end else begin
          e_word = exp_q.pop_front();
          chk("word", dout_o, e_word);
        end
        hs_cnt++;
        if (hs_cnt == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (perm_req_o) begin
        perm_cnt++;
        perm_flag = 1'b1;
        chk("perm_on_handshake", 64'(hs), 64'd1);
        chk("perm_at_block_end", 64'(hs_cnt % cur_rate), 64'd0);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = dout_valid_o && !dout_ready_i;
      prev_dout  = dout_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_run(input bit mode);
    cur_rate = mode ? 17 : 21;
    hs_cnt = 0; perm_cnt = 0; done_cnt = 0; valid_cnt = 0;
    first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    perm_flag = 1'b0;
    exp_q.delete();
  endtask

  // Full squeeze with a permutation model answering each request after lat cycles.
  task automatic run_sq(input bit mode, input int len, input int rdy_pct, input int lat);
    int blk, cd, t, exp_perm;
    bit pending;
    clear_run(mode);
    for (int i = 0; i < len; i++)
      exp_q.push_back(base_tab[i / cur_rate] + 64'(i % cur_rate));
    exp_perm = (len == 0) ? 0 : (len - 1) / cur_rate;
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = mode; len_words_i = 16'(len);
    dout_ready_i = ($urandom_range(99) < rdy_pct);
    start_cyc = cyc;
    blk = 0; pending = (len > 0); cd = lat; t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(posedge clk); #1;
      start_i = 1'b0; state_valid_i = 1'b0;
      dout_ready_i = ($urandom_range(99) < rdy_pct);
      if (perm_flag) begin
        perm_flag = 1'b0; pending = 1'b1; cd = lat;
      end
      if (pending) begin
        if (cd <= 1) begin
          state_i = mk_state(base_tab[blk], cur_rate);
          state_valid_i = 1'b1;
          blk++;
          pending = 1'b0;
        end else cd--;
      end
      t++;
    end
    chk("done_seen_in_budget", 64'(done_cnt != 0), 64'd1);
    @(posedge clk); #1;
    state_valid_i = 1'b0; dout_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("all_words_emitted", 64'(exp_q.size()), 64'd0);
    chk("perm_req_count", 64'(perm_cnt), 64'(exp_perm));
    chk("done_pulse_count", 64'(done_cnt), 64'd1);
    chk("idle_after_done", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; len_words_i = '0;
    state_i = '0; state_valid_i = 1'b0; dout_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(dout_valid_o), 64'd0);
    chk("rst_dout", dout_o, 64'd0);
    chk("rst_perm", 64'(perm_req_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_n = 1'b1;

    // 1: SHAKE128, 5 words back to back.
    base_tab[0] = 64'd0;
    run_sq(1'b0, 5, 100, 1);
    chk("t1_consecutive", 64'(last_hs_cyc - first_hs_cyc), 64'd4);
    chk("t1_done_gap", 64'(done_cyc - last_hs_cyc), 64'd1);

    // 2: SHAKE256, 20 words across two blocks.
    base_tab[0] = 64'd0; base_tab[1] = 64'd100;
    run_sq(1'b1, 20, 100, 1);
    chk("t2_done_gap", 64'(done_cyc - last_hs_cyc), 64'd1);

    // 3: SHAKE128, exactly one full block.
    base_tab[0] = 64'h1234_0000;
    run_sq(1'b0, 21, 100, 2);
    chk("t3_consecutive", 64'(last_hs_cyc - first_hs_cyc), 64'd20);
    chk("t3_done_gap", 64'(done_cyc - last_hs_cyc), 64'd1);

    // 4: zero-length request.
    run_sq(1'b0, 0, 100, 1);
    chk("t4_done_latency_ok", 64'((done_cyc - start_cyc) <= 2), 64'd1);
    chk("t4_no_valid", 64'(valid_cnt), 64'd0);

    // 5: test 2 with a 50% ready consumer.
    base_tab[0] = 64'd0; base_tab[1] = 64'd100;
    run_sq(1'b1, 20, 50, 3);

    // 6: reset while word 3 of test 2 is on the bus.
    clear_run(1'b1);
    for (int i = 0; i < 20; i++) exp_q.push_back(base_tab[i / 17] + 64'(i % 17));
    @(posedge clk); #1;
    start_i = 1'b1; mode_i = 1'b1; len_words_i = 16'd20; dout_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    state_i = mk_state(base_tab[0], 17); state_valid_i = 1'b1;
    @(posedge clk); #1;
    state_valid_i = 1'b0;
    t = 0;
    while (hs_cnt < 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t6_reached_word3", 64'(hs_cnt >= 3), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_rst_valid", 64'(dout_valid_o), 64'd0);
    chk("t6_rst_dout", dout_o, 64'd0);
    chk("t6_rst_perm", 64'(perm_req_o), 64'd0);
    chk("t6_rst_done", 64'(done_o), 64'd0);
    exp_q.delete();
    dout_ready_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_no_done_after_abort", 64'(done_cnt), 64'd0);
    run_sq(1'b1, 20, 100, 1);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 8; b++) base_tab[b] = {$urandom, $urandom};
      run_sq(1'($urandom_range(1)), int'($urandom_range(60, 1)),
             int'($urandom_range(100, 20)), int'($urandom_range(4, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
